booth_divider_24by12: RTL and testbench
=======================================

Name: booth_divider_24by12

Overview:
- Sequential unsigned divider, the inverse of the 12x12 radix-4 multiplier path: 24-bit dividend / 12-bit divisor -> 12-bit quotient + 12-bit remainder.
- Radix-4 restoring algorithm; retires 2 quotient bits per cycle using trial subtractions of D, 2D and 3D.
- Used to recover an operand from a product and to check multiplier results in-system.
- Valid/ready handshake on input and output.

Parameters:
- N, 12, divisor/quotient/remainder width; dividend is 2N. Must be even. Iterations = N/2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient would not fit in N bits

Behaviour:
- Reset (rst_n=0, async): state=IDLE. in_ready=1 once reset is released. out_valid=0. quotient=0, remainder=0, div_by_zero=0, overflow=0. All internal registers are cleared.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready at a rising edge. Dividend and divisor are sampled only at that edge.
  - divisor==0 -> DONE. div_by_zero=1, quotient=all ones, remainder=dividend[N-1:0].
  - Else if dividend[2N-1:N] >= divisor -> DONE. overflow=1, quotient=all ones, remainder=0.
  - Else -> CALC. Partial remainder PR=dividend[2N-1:N]; low half goes into a shift register; iteration counter=0.
- CALC: in_ready=0. One iteration per cycle, N/2 iterations in total.
  - T = {PR, next 2 dividend bits MSB-first}, N+2 bits wide.
  - Digit q = 3 if T>=3D, else 2 if T>=2D, else 1 if T>=D, else 0.
  - PR = T - q*D. PR always stays < D, so it fits in N bits.
  - Shift q into the quotient LSBs.
  - 2D and 3D are precomputed at acceptance, N+2 bits wide, with no truncation.
  - After the iteration with counter = N/2-1: load quotient/remainder outputs, go to DONE.
- DONE: out_valid=1; in_ready=0. Outputs are held stable until out_valid&&out_ready.
  - On the handshake edge: out_valid=0, flags clear, state -> IDLE. quotient and remainder keep their values.
- Latency, normal case: acceptance edge k; out_valid is high after edge k+N/2 (k+6 for N=12).
- Latency, error case: out_valid is high after edge k.
- Throughput: one operation in flight. The earliest next acceptance is the edge after the output handshake, because IDLE is re-entered first.
- The acceptance condition does not depend on out_ready.
- Out-of-range case: overflow and div_by_zero are mutually exclusive. div_by_zero takes priority.
- Invariant for normal results: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Multiplier inverse: dividend=24'hFFE001, divisor=12'hFFF -> quotient=12'hFFF, remainder=0, flags 0. out_valid rises 6 cycles after acceptance.
- Small values: dividend=24'd1000, divisor=12'd7 -> quotient=12'd142, remainder=12'd6. Then dividend=24'd6, divisor=12'd7 -> quotient=0, remainder=6.
- Error cases:
  - divisor=0, dividend=24'h000ABC -> div_by_zero=1, quotient=12'hFFF, remainder=12'hABC, out_valid one cycle after acceptance.
  - dividend=24'h123456, divisor=12'h100 -> overflow=1, quotient=12'hFFF, remainder=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs and out_valid stay stable; in_ready stays 0; a new in_valid is not accepted.
  - Raise out_ready -> IDLE on the next edge, then the new operation is accepted.
- Reset mid-CALC: assert rst_n=0 on iteration 3 -> out_valid, quotient and remainder go to 0 immediately, with no clock needed. After release, a fresh 24'd1000/12'd7 gives 142 r 6.
- Randomized sweep: 10k random operand pairs plus the boundaries 24'h0, 24'hFFEFFF/12'hFFF, and divisor=1 with dividend<24'h1000. Check the quotient/remainder invariant and the flags against a reference model.

Source files
------------

// File: rtl/booth_divider_24by12.sv
// rtl/booth_divider_24by12.sv - sequential radix-4 restoring divider, 2N-bit dividend / N-bit divisor
// Retires two quotient bits per cycle using trial subtractions of D, 2D and 3D.
`timescale 1ns/1ps
module booth_divider_24by12 #(
   parameter int N = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);
   localparam int CW = $clog2(N/2 + 1);
   localparam logic [CW-1:0] LAST = CW'(N/2 - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [N-1:0]  pr, low, qacc, d1;
   logic [N+1:0]  d2, d3, t;
   logic [CW-1:0] cnt;
   logic [1:0]    digit;
   logic [N-1:0]  sub, pr_nxt, q_nxt;
   logic          zero_div, hi_ge;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign zero_div  = (divisor == '0);
   assign hi_ge     = (dividend[2*N-1:N] >= divisor);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = (zero_div || hi_ge) ? DONE : CALC;
         CALC: if (cnt == LAST) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The result is below D < 2^N, so the subtraction can be done modulo 2^N.
   always_comb begin
      t     = {pr, low[N-1:N-2]};
      digit = 2'd0;
      sub   = '0;
      if (t >= d3) begin
         digit = 2'd3;
         sub   = d3[N-1:0];
      end else if (t >= d2) begin
         digit = 2'd2;
         sub   = d2[N-1:0];
      end else if (t >= {2'b00, d1}) begin
         digit = 2'd1;
         sub   = d1;
      end
      pr_nxt = t[N-1:0] - sub;
      q_nxt  = {qacc[N-3:0], digit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr          <= '0;
         low         <= '0;
         qacc        <= '0;
         d1          <= '0;
         d2          <= '0;
         d3          <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               d1   <= divisor;
               d2   <= {1'b0, divisor, 1'b0};
               d3   <= {1'b0, divisor, 1'b0} + {2'b00, divisor};
               pr   <= dividend[2*N-1:N];
               low  <= dividend[N-1:0];
               qacc <= '0;
               cnt  <= '0;
               if (zero_div) begin
                  div_by_zero <= 1'b1;
                  quotient    <= '1;
                  remainder   <= dividend[N-1:0];
               end else if (hi_ge) begin
                  overflow  <= 1'b1;
                  quotient  <= '1;
                  remainder <= '0;
               end
            end
            CALC: begin
               pr   <= pr_nxt;
               low  <= {low[N-3:0], 2'b00};
               qacc <= q_nxt;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  quotient  <= q_nxt;
                  remainder <= pr_nxt;
               end
            end
            DONE: if (out_ready) begin
               div_by_zero <= 1'b0;
               overflow    <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_divider_24by12.sv
// tb/tb_booth_divider_24by12.sv - self-checking bench: vector table, corner sequences, random sweep
`timescale 1ns/1ps
module tb_booth_divider_24by12;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [23:0] dividend;
   logic [11:0] divisor, quotient, remainder;
   logic        div_by_zero, overflow;

   int tests = 0;
   int fails = 0;

   booth_divider_24by12 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] a;
      logic [11:0] b;
      logic [11:0] q;
      logic [11:0] r;
      logic        dz;
      logic        ov;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void model(input logic [23:0] a, input logic [11:0] b,
                                 output logic [11:0] q, output logic [11:0] r,
                                 output logic dz, output logic ov, output int lat);
      int unsigned qa;
      dz = 1'b0; ov = 1'b0; lat = 6;
      if (b == 0) begin
         dz = 1'b1; q = 12'hFFF; r = a[11:0]; lat = 0;
      end else begin
         qa = int'(a) / int'(b);
         if (qa > 4095) begin
            ov = 1'b1; q = 12'hFFF; r = 12'h0; lat = 0;
         end else begin
            q = 12'(qa); r = 12'(int'(a) % int'(b));
         end
      end
   endfunction

   task automatic issue(input logic [23:0] a, input logic [11:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("issue_in_ready", in_ready, 1);
      dividend = a; divisor = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic collect(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("out_valid_arrives", out_valid, 1);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ack_out_valid_low", out_valid, 0);
      chk("ack_in_ready_high", in_ready, 1);
   endtask

   task automatic run_op(input vec_t v);
      int lat;
      issue(v.a, v.b);
      collect(lat);
      chk("latency", lat, v.lat);
      chk("quotient", quotient, v.q);
      chk("remainder", remainder, v.r);
      chk("div_by_zero", div_by_zero, v.dz);
      chk("overflow", overflow, v.ov);
      ack();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[11];
      vec_t v;
      int lat;
      logic [23:0] a;
      logic [11:0] b;

      vecs = '{
         '{24'hFFE001, 12'hFFF, 12'hFFF, 12'h000, 1'b0, 1'b0, 6},
         '{24'd1000,   12'd7,   12'd142, 12'd6,   1'b0, 1'b0, 6},
         '{24'd6,      12'd7,   12'd0,   12'd6,   1'b0, 1'b0, 6},
         '{24'h000ABC, 12'h000, 12'hFFF, 12'hABC, 1'b1, 1'b0, 0},
         '{24'h123456, 12'h100, 12'hFFF, 12'h000, 1'b0, 1'b1, 0},
         '{24'h000000, 12'd5,   12'd0,   12'd0,   1'b0, 1'b0, 6},
         '{24'hFFEFFF, 12'hFFF, 12'hFFF, 12'hFFE, 1'b0, 1'b0, 6},
         '{24'h000FFF, 12'd1,   12'hFFF, 12'h000, 1'b0, 1'b0, 6},
         '{24'h001000, 12'd1,   12'hFFF, 12'h000, 1'b0, 1'b1, 0},
         '{24'h000000, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 0},
         '{24'h0FFFFF, 12'h100, 12'hFFF, 12'h0FF, 1'b0, 1'b0, 6}
      };

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_by_zero", div_by_zero, 0);
      chk("rst_overflow", overflow, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      foreach (vecs[i]) run_op(vecs[i]);

      // backpressure: result held, new request refused until handshake
      issue(24'd1000, 12'd7);
      collect(lat);
      chk("bp_latency", lat, 6);
      dividend = 24'd6; divisor = 12'd7; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_quotient", quotient, 142);
         chk("bp_remainder", remainder, 6);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_out_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_accepted", in_ready, 0);
      collect(lat);
      chk("bp_next_latency", lat, 6);
      chk("bp_next_quotient", quotient, 0);
      chk("bp_next_remainder", remainder, 6);
      ack();

      // reset in the middle of the calculation
      issue(24'd1000, 12'd7);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      v = '{24'd1000, 12'd7, 12'd142, 12'd6, 1'b0, 1'b0, 6};
      run_op(v);

      // randomized sweep against the arithmetic model
      for (int i = 0; i < 10000; i++) begin
         a = 24'($urandom);
         b = 12'($urandom);
         if (i % 16 == 3) begin
            b = 12'd1;
            a = 24'($urandom_range(0, 'hFFF));
         end else if (i % 37 == 5) begin
            b = 12'd0;
         end else if (i % 4 == 1 && b != 0) begin
            a[23:12] = 12'($urandom_range(0, int'(b) - 1));
         end
         v.a = a; v.b = b;
         model(a, b, v.q, v.r, v.dz, v.ov, v.lat);
         issue(a, b);
         collect(lat);
         chk("rnd_latency", lat, v.lat);
         chk("rnd_quotient", quotient, v.q);
         chk("rnd_remainder", remainder, v.r);
         chk("rnd_div_by_zero", div_by_zero, v.dz);
         chk("rnd_overflow", overflow, v.ov);
         if (!v.dz && !v.ov) begin
            chk("rnd_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rnd_rem_lt_div", 32'(remainder < b), 1);
         end
         ack();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
